// File: rtl/norm_arbiter.sv
// norm_arbiter: round-robin arbiter that shares one pipelined normalizer
// between requester A (adder) and requester B (multiplier). Each requester
// may have one operation outstanding; its result is buffered in a per-requester
// register and held until the requester accepts it.
module norm_arbiter #(
    parameter int NORM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    // Requester A (adder)
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [52:0] a_mantissa,
    input  logic [10:0] a_exp,
    output logic        a_resp_valid,
    input  logic        a_resp_ready,
    output logic [52:0] a_res_mantissa,
    output logic [10:0] a_res_exp,

    // Requester B (multiplier)
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [52:0] b_mantissa,
    input  logic [10:0] b_exp,
    output logic        b_resp_valid,
    input  logic        b_resp_ready,
    output logic [52:0] b_res_mantissa,
    output logic [10:0] b_res_exp,

    // Shared normalizer
    output logic        norm_enable,
    output logic [52:0] norm_mantissa,
    output logic [10:0] norm_exp,
    input  logic [52:0] norm_res_mantissa,
    input  logic [10:0] norm_res_exp
);

    // Identity of a requester; used both for the round-robin pointer and
    // for the tag that travels down the pipeline with each issue.
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    owner_t                last_grant;
    logic                  busy_a;
    logic                  busy_b;
    logic                  elig_a;
    logic                  elig_b;
    logic                  grant_a;
    logic                  grant_b;
    logic                  issue;
    owner_t                issue_tag;
    logic [NORM_LAT-1:0]   pipe_valid;
    owner_t                pipe_tag [NORM_LAT];
    logic                  capture_a;
    logic                  capture_b;
    logic                  resp_done_a;
    logic                  resp_done_b;

    // A requester may compete only when it has a request and nothing
    // outstanding; reset blocks all grants so req_ready stays low.
    always_comb begin
        elig_a = a_req_valid & ~busy_a & ~rst;
        elig_b = b_req_valid & ~busy_b & ~rst;
    end

    // Round-robin grant: on a tie the requester that did not win the last
    // issue gets the normalizer.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (elig_a && elig_b) begin
            if (last_grant == OWNER_B) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else begin
            grant_a = elig_a;
            grant_b = elig_b;
        end
    end

    // Issue strobe and operand mux; operands are forced to zero when idle so
    // the normalizer never sees stale data.
    always_comb begin
        issue         = grant_a | grant_b;
        issue_tag     = grant_b ? OWNER_B : OWNER_A;
        a_req_ready   = grant_a;
        b_req_ready   = grant_b;
        norm_enable   = issue;
        norm_mantissa = '0;
        norm_exp      = '0;
        if (grant_a) begin
            norm_mantissa = a_mantissa;
            norm_exp      = a_exp;
        end else if (grant_b) begin
            norm_mantissa = b_mantissa;
            norm_exp      = b_exp;
        end
    end

    // Round-robin pointer; only moves when an operation is actually issued,
    // and starts at B so that A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_B;
        end else if (issue) begin
            last_grant <= issue_tag;
        end
    end

    // Shadow pipeline that tracks which requester owns each normalizer stage;
    // its last stage lines up with the normalizer's output.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < NORM_LAT; i++) begin
                pipe_tag[i] <= OWNER_A;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_tag[0]   <= issue_tag;
            for (int i = 1; i < NORM_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
        end
    end

    // Route the normalizer output to its owner, and detect the response
    // handshakes that free each requester.
    always_comb begin
        capture_a   = pipe_valid[NORM_LAT-1] & (pipe_tag[NORM_LAT-1] == OWNER_A);
        capture_b   = pipe_valid[NORM_LAT-1] & (pipe_tag[NORM_LAT-1] == OWNER_B);
        resp_done_a = a_resp_valid & a_resp_ready;
        resp_done_b = b_resp_valid & b_resp_ready;
    end

    // Busy flag for A: held from its request handshake until its result has
    // been accepted, which keeps at most one A operation outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_a <= 1'b0;
        end else if (grant_a) begin
            busy_a <= 1'b1;
        end else if (resp_done_a) begin
            busy_a <= 1'b0;
        end
    end

    // Busy flag for B, same policy as A.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_b <= 1'b0;
        end else if (grant_b) begin
            busy_b <= 1'b1;
        end else if (resp_done_b) begin
            busy_b <= 1'b0;
        end
    end

    // A's result buffer: captured straight from the normalizer, held stable
    // while A is stalled, valid dropped once A accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_resp_valid   <= 1'b0;
            a_res_mantissa <= '0;
            a_res_exp      <= '0;
        end else if (capture_a) begin
            a_resp_valid   <= 1'b1;
            a_res_mantissa <= norm_res_mantissa;
            a_res_exp      <= norm_res_exp;
        end else if (resp_done_a) begin
            a_resp_valid   <= 1'b0;
        end
    end

    // B's result buffer, same behaviour as A's.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_resp_valid   <= 1'b0;
            b_res_mantissa <= '0;
            b_res_exp      <= '0;
        end else if (capture_b) begin
            b_resp_valid   <= 1'b1;
            b_res_mantissa <= norm_res_mantissa;
            b_res_exp      <= norm_res_exp;
        end else if (resp_done_b) begin
            b_resp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_norm_arbiter.sv
// tb_norm_arbiter: directed, table-driven bench for norm_arbiter with a
// behavioural normalizer model; one DUT at NORM_LAT=1 and one at NORM_LAT=3.
module tb_norm_arbiter;

    typedef struct packed {
        logic        is_b;
        logic [52:0] m;
        logic [10:0] e;
        logic [52:0] exp_m;
        logic [10:0] exp_e;
    } vec_t;

    vec_t vecs [6];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // NORM_LAT=1 instance signals
    logic        a_req_valid_1 = 0, a_req_ready_1, a_resp_valid_1, a_resp_ready_1 = 1;
    logic [52:0] a_mantissa_1 = '0, a_res_mantissa_1;
    logic [10:0] a_exp_1 = '0, a_res_exp_1;
    logic        b_req_valid_1 = 0, b_req_ready_1, b_resp_valid_1, b_resp_ready_1 = 1;
    logic [52:0] b_mantissa_1 = '0, b_res_mantissa_1;
    logic [10:0] b_exp_1 = '0, b_res_exp_1;
    logic        norm_enable_1;
    logic [52:0] norm_mantissa_1, norm_res_mantissa_1;
    logic [10:0] norm_exp_1, norm_res_exp_1;

    // NORM_LAT=3 instance signals
    logic        a_req_valid_3 = 0, a_req_ready_3, a_resp_valid_3, a_resp_ready_3 = 1;
    logic [52:0] a_mantissa_3 = '0, a_res_mantissa_3;
    logic [10:0] a_exp_3 = '0, a_res_exp_3;
    logic        b_req_valid_3 = 0, b_req_ready_3, b_resp_valid_3, b_resp_ready_3 = 1;
    logic [52:0] b_mantissa_3 = '0, b_res_mantissa_3;
    logic [10:0] b_exp_3 = '0, b_res_exp_3;
    logic        norm_enable_3;
    logic [52:0] norm_mantissa_3, norm_res_mantissa_3;
    logic [10:0] norm_exp_3, norm_res_exp_3;

    logic [63:0] model1;
    logic [63:0] model3 [3];

    norm_arbiter #(.NORM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid_1), .a_req_ready(a_req_ready_1),
        .a_mantissa(a_mantissa_1), .a_exp(a_exp_1),
        .a_resp_valid(a_resp_valid_1), .a_resp_ready(a_resp_ready_1),
        .a_res_mantissa(a_res_mantissa_1), .a_res_exp(a_res_exp_1),
        .b_req_valid(b_req_valid_1), .b_req_ready(b_req_ready_1),
        .b_mantissa(b_mantissa_1), .b_exp(b_exp_1),
        .b_resp_valid(b_resp_valid_1), .b_resp_ready(b_resp_ready_1),
        .b_res_mantissa(b_res_mantissa_1), .b_res_exp(b_res_exp_1),
        .norm_enable(norm_enable_1), .norm_mantissa(norm_mantissa_1), .norm_exp(norm_exp_1),
        .norm_res_mantissa(norm_res_mantissa_1), .norm_res_exp(norm_res_exp_1)
    );

    norm_arbiter #(.NORM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid_3), .a_req_ready(a_req_ready_3),
        .a_mantissa(a_mantissa_3), .a_exp(a_exp_3),
        .a_resp_valid(a_resp_valid_3), .a_resp_ready(a_resp_ready_3),
        .a_res_mantissa(a_res_mantissa_3), .a_res_exp(a_res_exp_3),
        .b_req_valid(b_req_valid_3), .b_req_ready(b_req_ready_3),
        .b_mantissa(b_mantissa_3), .b_exp(b_exp_3),
        .b_resp_valid(b_resp_valid_3), .b_resp_ready(b_resp_ready_3),
        .b_res_mantissa(b_res_mantissa_3), .b_res_exp(b_res_exp_3),
        .norm_enable(norm_enable_3), .norm_mantissa(norm_mantissa_3), .norm_exp(norm_exp_3),
        .norm_res_mantissa(norm_res_mantissa_3), .norm_res_exp(norm_res_exp_3)
    );

    always #5 clk = ~clk;

    // Normalizer model: shift left until the top bit is set, decrementing the
    // exponent per shift; a zero mantissa passes through untouched.
    function automatic logic [63:0] normalize(input logic [52:0] m, input logic [10:0] e);
        logic [52:0] mm;
        logic [10:0] ee;
        mm = m;
        ee = e;
        if (mm != '0) begin
            for (int i = 0; i < 53; i++) begin
                if (!mm[52]) begin
                    mm = mm << 1;
                    ee = ee - 11'd1;
                end
            end
        end
        return {ee, mm};
    endfunction

    // One-stage normalizer pipeline for dut1.
    always @(posedge clk) begin
        model1 <= normalize(norm_mantissa_1, norm_exp_1);
    end
    assign {norm_res_exp_1, norm_res_mantissa_1} = model1;

    // Three-stage normalizer pipeline for dut3.
    always @(posedge clk) begin
        model3[0] <= normalize(norm_mantissa_3, norm_exp_3);
        model3[1] <= model3[0];
        model3[2] <= model3[1];
    end
    assign {norm_res_exp_3, norm_res_mantissa_3} = model3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one requester of dut1.
    task automatic applyStimulus(input logic is_b, input logic valid, input logic [52:0] m, input logic [10:0] e);
        if (is_b) begin
            b_req_valid_1 = valid;
            b_mantissa_1  = m;
            b_exp_1       = e;
        end else begin
            a_req_valid_1 = valid;
            a_mantissa_1  = m;
            a_exp_1       = e;
        end
    endtask

    function automatic logic sel_ready(input logic is_b);
        return is_b ? b_req_ready_1 : a_req_ready_1;
    endfunction

    function automatic logic sel_resp_valid(input logic is_b);
        return is_b ? b_resp_valid_1 : a_resp_valid_1;
    endfunction

    function automatic logic [63:0] sel_res(input logic is_b);
        return is_b ? {b_res_exp_1, b_res_mantissa_1} : {a_res_exp_1, a_res_mantissa_1};
    endfunction

    // One isolated operation on dut1: issue, latency, data, and drop of valid.
    task automatic run_single(input vec_t v, input string tag);
        int n;
        tick();
        applyStimulus(v.is_b, 1'b1, v.m, v.e);
        n = 0;
        @(negedge clk);
        while (!sel_ready(v.is_b) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready"}, sel_ready(v.is_b), 1);
        checkOutput({tag, "_issue"}, {norm_enable_1, norm_exp_1, norm_mantissa_1}, {1'b1, v.e, v.m});
        n = 0;
        do begin
            tick();
            if (n == 0) applyStimulus(v.is_b, 1'b0, '0, '0);
            n++;
            @(negedge clk);
        end while (!sel_resp_valid(v.is_b) && n < 20);
        checkOutput({tag, "_latency"}, n, 2);
        checkOutput({tag, "_result"}, sel_res(v.is_b), {v.exp_e, v.exp_m});
        @(negedge clk);
        checkOutput({tag, "_drop"}, sel_resp_valid(v.is_b), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int b_done;
        int ia, ib, a_done3, b_done3, a_issue, b_issue;
        logic a_pend, b_pend, a_adv, b_adv;
        logic [63:0] a_expv, b_expv;

        vecs[0] = '{1'b0, 53'h4000000000000,  11'd1023, 53'h10000000000000, 11'd1021};
        vecs[1] = '{1'b1, 53'h0,              11'd5,    53'h0,              11'd5};
        vecs[2] = '{1'b0, 53'h1,              11'd1100, 53'h10000000000000, 11'd1048};
        vecs[3] = '{1'b1, 53'h0F0000000000,   11'd50,   53'h1E000000000000, 11'd41};
        vecs[4] = '{1'b1, 53'h1FFFFFFFFFFFFF, 11'd7,    53'h1FFFFFFFFFFFFF, 11'd7};
        vecs[5] = '{1'b0, 53'h3,              11'd2000, 53'h18000000000000, 11'd1949};

        // Reset: requests held high must not be accepted, all outputs zero.
        a_req_valid_1 = 1; b_req_valid_1 = 1; a_req_valid_3 = 1; b_req_valid_3 = 1;
        a_mantissa_1 = 53'h5; b_mantissa_1 = 53'h7;
        tick();
        @(negedge clk);
        checkOutput("rst_ready_1", {a_req_ready_1, b_req_ready_1}, 0);
        checkOutput("rst_ready_3", {a_req_ready_3, b_req_ready_3}, 0);
        checkOutput("rst_norm_1", {norm_enable_1, norm_exp_1, norm_mantissa_1}, 0);
        checkOutput("rst_resp_valid", {a_resp_valid_1, b_resp_valid_1, a_resp_valid_3, b_resp_valid_3}, 0);
        checkOutput("rst_res_1", {a_res_exp_1, a_res_mantissa_1, b_res_exp_1, b_res_mantissa_1}, 0);
        checkOutput("rst_res_3", {a_res_exp_3, a_res_mantissa_3, b_res_exp_3, b_res_mantissa_3}, 0);
        tick();
        a_req_valid_1 = 0; b_req_valid_1 = 0; a_req_valid_3 = 0; b_req_valid_3 = 0;
        rst = 0;

        // Tie after reset: A first, B back-to-back, next tie goes to A.
        tick();
        applyStimulus(1'b0, 1'b1, vecs[0].m, vecs[0].e);
        applyStimulus(1'b1, 1'b1, vecs[3].m, vecs[3].e);
        @(negedge clk);
        checkOutput("tie1_grant", {a_req_ready_1, b_req_ready_1}, 2'b10);
        checkOutput("tie1_norm", {norm_enable_1, norm_exp_1, norm_mantissa_1}, {1'b1, vecs[0].e, vecs[0].m});
        tick();
        a_req_valid_1 = 0;
        @(negedge clk);
        checkOutput("tie1_b_next", {a_req_ready_1, b_req_ready_1}, 2'b01);
        checkOutput("tie1_b_norm", {norm_enable_1, norm_exp_1, norm_mantissa_1}, {1'b1, vecs[3].e, vecs[3].m});
        tick();
        b_req_valid_1 = 0;
        @(negedge clk);
        checkOutput("tie1_a_resp", {a_resp_valid_1, a_res_exp_1, a_res_mantissa_1}, {1'b1, vecs[0].exp_e, vecs[0].exp_m});
        tick();
        @(negedge clk);
        checkOutput("tie1_b_resp", {b_resp_valid_1, b_res_exp_1, b_res_mantissa_1}, {1'b1, vecs[3].exp_e, vecs[3].exp_m});
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, vecs[2].m, vecs[2].e);
        applyStimulus(1'b1, 1'b1, vecs[4].m, vecs[4].e);
        @(negedge clk);
        checkOutput("tie2_grant", {a_req_ready_1, b_req_ready_1}, 2'b10);
        tick();
        a_req_valid_1 = 0;
        tick();
        b_req_valid_1 = 0;
        repeat (6) tick();

        // Table of single operations, including the zero-mantissa case.
        for (int i = 0; i < 6; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // A stalls on resp_ready for 12 cycles; B keeps issuing.
        tick();
        a_resp_ready_1 = 0;
        applyStimulus(1'b0, 1'b1, vecs[2].m, vecs[2].e);
        @(negedge clk);
        checkOutput("stall_a_issue", a_req_ready_1, 1);
        tick();
        a_req_valid_1 = 0;
        k = 0;
        @(negedge clk);
        while (!a_resp_valid_1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checkOutput("stall_a_resp", a_resp_valid_1, 1);
        tick();
        a_req_valid_1 = 1;
        applyStimulus(1'b1, 1'b1, vecs[5].m, vecs[5].e);
        b_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("stall_a_hold", {a_resp_valid_1, a_res_exp_1, a_res_mantissa_1}, {1'b1, vecs[2].exp_e, vecs[2].exp_m});
            checkOutput("stall_a_ready", a_req_ready_1, 0);
            if (b_resp_valid_1) begin
                checkOutput("stall_b_res", {b_res_exp_1, b_res_mantissa_1}, {vecs[5].exp_e, vecs[5].exp_m});
                b_done++;
            end
            tick();
        end
        checkOutput("stall_b_done", (b_done >= 3), 1);
        b_req_valid_1 = 0;
        a_req_valid_1 = 0;
        a_resp_ready_1 = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checkOutput("stall_a_drop", a_resp_valid_1, 0);
        repeat (6) tick();

        // Reset the cycle after an A issue discards the operation.
        tick();
        applyStimulus(1'b0, 1'b1, vecs[0].m, vecs[0].e);
        @(negedge clk);
        checkOutput("midrst_issue", a_req_ready_1, 1);
        tick();
        a_req_valid_1 = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_resp", a_resp_valid_1, 0);
            tick();
        end
        run_single(vecs[2], "midrst_after");

        // NORM_LAT=3: A and B issue on alternating cycles; check tag routing.
        ia = 0; ib = 3; a_done3 = 0; b_done3 = 0; a_issue = 0; b_issue = 0;
        a_pend = 0; b_pend = 0; a_adv = 0; b_adv = 0; a_expv = '0; b_expv = '0;
        tick();
        a_req_valid_3 = 1; a_mantissa_3 = vecs[ia].m; a_exp_3 = vecs[ia].e;
        b_req_valid_3 = 1; b_mantissa_3 = vecs[ib].m; b_exp_3 = vecs[ib].e;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (a_req_ready_3 && b_req_ready_3) begin
                checkOutput("il_double_grant", 1, 0);
            end
            if (a_resp_valid_3) begin
                checkOutput("il_a_pending", a_pend, 1);
                checkOutput("il_a_latency", cyc - a_issue, 4);
                checkOutput("il_a_data", {a_res_exp_3, a_res_mantissa_3}, a_expv);
                a_pend = 0;
                a_done3++;
            end
            if (b_resp_valid_3) begin
                checkOutput("il_b_pending", b_pend, 1);
                checkOutput("il_b_latency", cyc - b_issue, 4);
                checkOutput("il_b_data", {b_res_exp_3, b_res_mantissa_3}, b_expv);
                b_pend = 0;
                b_done3++;
            end
            if (a_req_ready_3) begin
                a_issue = cyc; a_pend = 1; a_adv = 1;
                a_expv = {vecs[ia].exp_e, vecs[ia].exp_m};
            end
            if (b_req_ready_3) begin
                b_issue = cyc; b_pend = 1; b_adv = 1;
                b_expv = {vecs[ib].exp_e, vecs[ib].exp_m};
            end
            tick();
            if (a_adv) begin
                ia = (ia + 1) % 6; a_mantissa_3 = vecs[ia].m; a_exp_3 = vecs[ia].e; a_adv = 0;
            end
            if (b_adv) begin
                ib = (ib + 1) % 6; b_mantissa_3 = vecs[ib].m; b_exp_3 = vecs[ib].e; b_adv = 0;
            end
        end
        a_req_valid_3 = 0;
        b_req_valid_3 = 0;
        checkOutput("il_a_count", (a_done3 >= 6), 1);
        checkOutput("il_b_count", (b_done3 >= 6), 1);
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/norm_arbiter.md
NORM_ARBITER -- requirements
Module: norm_arbiter

Interface
REQ-001 The block SHALL have parameter NORM_LAT, default 1, meaning the pipeline depth in cycles of the shared normalizer (legal 1..4).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a_req_valid  input  1  requester A (adder) has a mantissa/exponent to normalize.
REQ-006 a_req_ready  output  1  block accepts A's request this cycle.
REQ-007 a_mantissa  input  53 / a_exp  input  11  A's request operands.
REQ-008 a_resp_valid  output  1 / a_resp_ready  input  1  A's result handshake.
REQ-009 a_res_mantissa  output  53 / a_res_exp  output  11  A's normalized result.
REQ-010 b_req_valid, b_req_ready, b_mantissa, b_exp, b_resp_valid, b_resp_ready, b_res_mantissa, b_res_exp SHALL mirror REQ-005..009 for requester B (multiplier).
REQ-011 norm_enable  output  1  issue strobe to the shared normalizer.
REQ-012 norm_mantissa  output  53 / norm_exp  output  11  operands to the normalizer.
REQ-013 norm_res_mantissa  input  53 / norm_res_exp  input  11  normalizer outputs, valid NORM_LAT cycles after issue.

Function
REQ-014 Each requester SHALL have one busy flag: set on its request handshake, cleared the cycle after its response handshake (resp_valid & resp_ready).
REQ-015 A requester SHALL be eligible when req_valid=1 and busy=0.
REQ-016 Grant: one eligible requester wins; if both are eligible, the one not granted last wins (round-robin). last_grant SHALL update only on an issue.
REQ-017 x_req_ready SHALL be 1 only for the granted requester. It may depend combinationally on req_valid, and is 0 whenever busy=1.
REQ-018 Issue cycle: norm_enable=1, norm_mantissa/norm_exp = the granted requester's operands. Otherwise norm_enable=0 and norm_mantissa=0, norm_exp=0.
REQ-019 A NORM_LAT-deep shift register SHALL carry {valid, tag} alongside each issue. The tag identifies A or B.
REQ-020 When the last stage is valid, norm_res_mantissa/norm_res_exp SHALL be captured into the tagged requester's result register at that clock edge.
REQ-021 x_resp_valid SHALL rise the cycle after capture, i.e. issue at cycle T gives resp_valid high at T+NORM_LAT+1.
REQ-022 x_resp_valid and the x_res_* outputs SHALL hold stable until x_resp_ready=1. They drop the cycle after the handshake.
REQ-023 At most one operation per requester SHALL be outstanding (in flight or buffered). Capture therefore never overwrites an unconsumed result.
REQ-024 Results SHALL be forwarded unmodified, including an all-zero mantissa.
REQ-025 A response handshake on one requester and an issue from the other SHALL proceed in the same cycle without interaction.
REQ-026 Back-to-back issues (A then B on consecutive cycles) SHALL be supported; the normalizer sees one issue per cycle maximum.
REQ-027 Holding resp_ready low SHALL stall only that requester; the other continues at full rate.

Reset
REQ-028 rst=1 at a clock edge SHALL clear:
- busy flags, pipeline valid bits, resp_valid outputs, norm_enable;
- all result and operand outputs, to 0;
- last_grant to B, so that A wins the first tie.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered results; no response appears for them after reset.
REQ-030 req_ready SHALL be 0 while rst=1.

Verification
REQ-031 Single A op, NORM_LAT=1: a_mantissa=53'h4000000000000, a_exp=1023 issued at T -> a_resp_valid at T+2 with 53'h10000000000000, exp 1021, using the normalizer model.
REQ-032 Simultaneous A and B valid after reset -> A issues first; B issues next cycle; the next tie goes to A.
REQ-033 A resp_ready held low 10 cycles -> a_res_* stable and a_req_ready=0 throughout; B completes 3 ops meanwhile.
REQ-034 Zero mantissa from B, b_exp=5 -> b_res_mantissa=0, b_res_exp=5 returned unchanged.
REQ-035 rst asserted the cycle after an A issue -> a_resp_valid never rises; the next A request issues normally with correct data.
REQ-036 NORM_LAT=3, A and B interleaved every cycle -> each result routed to its own tag with latency 4 cycles.
